// File: rtl/pergate_ctrl_pkg.sv
// Shared types and helpers for the per-gate sumcheck round controllers.
`include "field_arith_defs.v"

package pergate_ctrl_pkg;

  localparam int unsigned F_NBITS = `F_NBITS;
  localparam logic [F_NBITS-1:0] F_Q = `F_Q;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_WAIT_TAU,
    ST_MUL,
    ST_SUB,
    ST_NEXT
  } pergate_state_t;

  // Width of a round counter that must hold 0 .. ngatebits.
  function automatic int unsigned round_idx_width(input int unsigned ngatebits);
    return $clog2(ngatebits + 1);
  endfunction

endpackage

// File: rtl/field_arith_defs.v
// Field parameters shared by every field-arithmetic block.
`ifndef FIELD_ARITH_DEFS_V
`define FIELD_ARITH_DEFS_V
`define F_NBITS 61
`define F_Q 61'h1FFFFFFFFFFFFFFF
`endif

// File: rtl/field_sub_mod.sv
// Combinational modular subtract: c = (a - b) mod F_Q, with a, b < F_Q.
`include "field_arith_defs.v"

module field_sub_mod (
  input  logic [`F_NBITS-1:0] a,
  input  logic [`F_NBITS-1:0] b,
  output logic [`F_NBITS-1:0] c
);

  // One extra bit keeps a + F_Q from overflowing before b is removed.
  always_comb begin
    if (a >= b) c = `F_NBITS'({1'b0, a} - {1'b0, b});
    else        c = `F_NBITS'({1'b0, a} + {1'b0, `F_Q} - {1'b0, b});
  end

endmodule

// File: rtl/pergate_am012_round_ctrl.sv
// Drives one pergate_compute_am012 datapath through all lgG sumcheck rounds
// of a gate, folding the running term with each Verifier challenge.
`include "field_arith_defs.v"

module pergate_am012_round_ctrl
  import pergate_ctrl_pkg::*;
#(
  parameter int unsigned NGATEBITS = 8
) (
  input  logic                                        clk,
  input  logic                                        rstb,
  input  logic                                        start,
  input  logic [NGATEBITS-1:0]                        gate_label,
  input  logic [`F_NBITS-1:0]                         init_val,
  output logic                                        am_en,
  output logic                                        am_gate_id_bit,
  output logic [`F_NBITS-1:0]                         am_addmul_in,
  input  logic                                        am_ready_pulse,
  output logic                                        round_valid,
  output logic [round_idx_width(NGATEBITS)-1:0]       round_idx,
  input  logic                                        tau_valid,
  input  logic [`F_NBITS-1:0]                         tau,
  output logic                                        mul_en,
  output logic [`F_NBITS-1:0]                         mul_a,
  output logic [`F_NBITS-1:0]                         mul_b,
  input  logic                                        mul_ready_pulse,
  input  logic [`F_NBITS-1:0]                         mul_c,
  output logic                                        busy,
  output logic                                        done_pulse,
  output logic [`F_NBITS-1:0]                         final_val
);

  localparam int unsigned RIDX_W = round_idx_width(NGATEBITS);
  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NGATEBITS - 1);

  pergate_state_t        state;
  logic [NGATEBITS-1:0]  g_reg;
  logic [`F_NBITS-1:0]   acc;
  logic [`F_NBITS-1:0]   tau_reg;
  logic [`F_NBITS-1:0]   p_reg;
  logic [`F_NBITS-1:0]   sub_res;
  logic                  cur_bit;

  // acc and tau_reg only change at fold/capture, so they serve directly as
  // the held datapath and multiplier operands.
  assign am_addmul_in   = acc;
  assign mul_a          = acc;
  assign mul_b          = tau_reg;
  assign busy           = (state != ST_IDLE);
  assign am_gate_id_bit = cur_bit;

  // Select g[round_idx] without an over-wide bit index.
  always_comb begin
    cur_bit = 1'b0;
    for (int unsigned i = 0; i < NGATEBITS; i++) begin
      if (round_idx == RIDX_W'(i)) cur_bit = g_reg[i];
    end
  end

  // acc*tau already sits in p_reg; acc - acc*tau yields (1 - tau) * acc.
  field_sub_mod u_sub (
    .a (acc),
    .b (p_reg),
    .c (sub_res)
  );

  // Round sequencer with registered strobes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      g_reg       <= '0;
      acc         <= '0;
      tau_reg     <= '0;
      p_reg       <= '0;
      round_idx   <= '0;
      am_en       <= 1'b0;
      round_valid <= 1'b0;
      mul_en      <= 1'b0;
      done_pulse  <= 1'b0;
      final_val   <= '0;
    end else begin
      am_en      <= 1'b0;
      mul_en     <= 1'b0;
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            g_reg     <= gate_label;
            acc       <= init_val;
            round_idx <= '0;
            am_en     <= 1'b1;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (am_ready_pulse) begin
            round_valid <= 1'b1;
            state       <= ST_WAIT_TAU;
          end
        end
        ST_WAIT_TAU: begin
          if (tau_valid) begin
            tau_reg     <= tau;
            round_valid <= 1'b0;
            mul_en      <= 1'b1;
            state       <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_ready_pulse) begin
            if (cur_bit) begin
              acc   <= mul_c;
              state <= ST_NEXT;
            end else begin
              p_reg <= mul_c;
              state <= ST_SUB;
            end
          end
        end
        ST_SUB: begin
          acc   <= sub_res;
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (round_idx == LAST_IDX) begin
            final_val  <= acc;
            done_pulse <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            round_idx <= round_idx + RIDX_W'(1);
            am_en     <= 1'b1;
            state     <= ST_EVAL;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pergate_am012_round_ctrl.sv
// Bench for pergate_am012_round_ctrl with a 1-cycle datapath and 3-cycle
// multiplier environment, checked against a modular-arithmetic gate model.
module tb_pergate_am012_round_ctrl;
  import pergate_ctrl_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned FW = F_NBITS;
  localparam int unsigned RW = round_idx_width(N);

  typedef logic [FW-1:0] fe_t;

  logic          clk, rstb, start;
  logic [N-1:0]  gate_label;
  fe_t           init_val, am_addmul_in, tau, mul_a, mul_b, mul_c, final_val;
  logic          am_en, am_gate_id_bit, am_ready_pulse, round_valid;
  logic [RW-1:0] round_idx;
  logic          tau_valid, mul_en, mul_ready_pulse, busy, done_pulse;

  logic          dp_rdy, inj_mul;
  logic [2:0]    mul_v;
  fe_t           prod_q;

  int checks = 0;
  int errors = 0;
  int am_cnt = 0, mul_cnt = 0, done_cnt = 0;

  pergate_am012_round_ctrl #(.NGATEBITS(N)) dut (
    .clk(clk), .rstb(rstb), .start(start), .gate_label(gate_label),
    .init_val(init_val), .am_en(am_en), .am_gate_id_bit(am_gate_id_bit),
    .am_addmul_in(am_addmul_in), .am_ready_pulse(am_ready_pulse),
    .round_valid(round_valid), .round_idx(round_idx), .tau_valid(tau_valid),
    .tau(tau), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready_pulse(mul_ready_pulse), .mul_c(mul_c), .busy(busy),
    .done_pulse(done_pulse), .final_val(final_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fe_t fmul(input fe_t a, input fe_t b);
    logic [2*FW-1:0] aw, bw, p;
    aw = a;
    bw = b;
    p  = aw * bw;
    return fe_t'(p % {{FW{1'b0}}, F_Q});
  endfunction

  function automatic fe_t fsub(input fe_t a, input fe_t b);
    logic [FW:0] s;
    s = {1'b0, a} + {1'b0, F_Q} - {1'b0, b};
    return fe_t'(s % {1'b0, F_Q});
  endfunction

  function automatic fe_t rand_fe();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return fe_t'(r % {3'b0, F_Q});
  endfunction

  // Environment: datapath answers one cycle after am_en.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) dp_rdy <= 1'b0;
    else       dp_rdy <= am_en;
  end
  assign am_ready_pulse = dp_rdy;

  // Environment: multiplier answers three cycles after mul_en.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mul_v  <= '0;
      prod_q <= '0;
    end else begin
      mul_v <= {mul_v[1:0], mul_en};
      if (mul_en) prod_q <= fmul(mul_a, mul_b);
    end
  end
  assign mul_ready_pulse = mul_v[2] | inj_mul;
  assign mul_c           = prod_q;

  always @(negedge clk) begin
    if (am_en)      am_cnt++;
    if (mul_en)     mul_cnt++;
    if (done_pulse) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rv(input string tag);
    int unsigned n;
    n = 0;
    while (!round_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_rv_wait"}, round_valid, 1);
  endtask

  task automatic run_gate(input string name, input logic [N-1:0] g, input fe_t init,
                          input fe_t taus [N], input bit stray, output fe_t got);
    fe_t exp_acc;
    int  b_am, b_mul, b_done;
    int unsigned n;
    exp_acc = init;
    b_am = am_cnt; b_mul = mul_cnt; b_done = done_cnt;
    gate_label = g; init_val = init; start = 1'b1;
    step();
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    if (stray) begin
      tau_valid = 1'b1; tau = rand_fe();
      step();
      check({name, "_tau_in_eval_rv"}, round_valid, 0);
      step();
      tau_valid = 1'b0;
      check({name, "_tau_with_ready_rv"}, round_valid, 1);
      check({name, "_tau_with_ready_mul"}, mul_cnt - b_mul, 0);
      inj_mul = 1'b1; start = 1'b1; gate_label = ~g; init_val = init ^ fe_t'(5);
      step();
      inj_mul = 1'b0; start = 1'b0;
      check({name, "_stray_mul_rv"}, round_valid, 1);
      check({name, "_stray_mul_cnt"}, mul_cnt - b_mul, 0);
      check({name, "_stray_idx"}, round_idx, 0);
    end
    for (int unsigned k = 0; k < N; k++) begin
      wait_rv($sformatf("%s_r%0d", name, k));
      check($sformatf("%s_r%0d_idx", name, k), round_idx, k);
      check($sformatf("%s_r%0d_gbit", name, k), am_gate_id_bit, g[k]);
      check($sformatf("%s_r%0d_term", name, k), am_addmul_in, exp_acc);
      check($sformatf("%s_r%0d_am_en_cnt", name, k), am_cnt - b_am, k + 1);
      check($sformatf("%s_r%0d_mul_en_cnt", name, k), mul_cnt - b_mul, k);
      tau_valid = 1'b1; tau = taus[k];
      step();
      tau_valid = 1'b0;
      check($sformatf("%s_r%0d_rv_drop", name, k), round_valid, 0);
      check($sformatf("%s_r%0d_mul_en", name, k), mul_en, 1);
      check($sformatf("%s_r%0d_mul_ops", name, k), {mul_a, mul_b}, {exp_acc, taus[k]});
      if (g[k]) exp_acc = fmul(taus[k], exp_acc);
      else      exp_acc = fmul(fsub(fe_t'(1), taus[k]), exp_acc);
    end
    n = 0;
    while (!done_pulse && n < 50) begin
      step();
      n++;
    end
    check({name, "_done_wait"}, done_pulse, 1);
    check({name, "_final"}, final_val, exp_acc);
    got = final_val;
    step();
    check({name, "_done_once"}, done_cnt - b_done, 1);
    check({name, "_idle"}, busy, 0);
    check({name, "_am_en_total"}, am_cnt - b_am, N);
    check({name, "_mul_en_total"}, mul_cnt - b_mul, N);
  endtask

  initial begin
    fe_t taus [N];
    fe_t got;
    rstb = 1'b0; start = 1'b0; gate_label = '0; init_val = '0;
    tau_valid = 1'b0; tau = '0; inj_mul = 1'b0;
    step(); step();
    check("reset_outputs",
          {am_en, am_gate_id_bit, am_addmul_in, round_valid, round_idx, mul_en,
           mul_a, mul_b, busy, done_pulse, final_val}, '0);
    rstb = 1'b1;
    step();

    taus = '{fe_t'(2), fe_t'(3), fe_t'(5)};
    run_gate("t1", 3'b101, fe_t'(1), taus, 1'b0, got);
    check("t1_final_const", got, F_Q - fe_t'(20));

    taus = '{fe_t'(0), fe_t'(0), fe_t'(0)};
    run_gate("t3", 3'b000, fe_t'(7), taus, 1'b0, got);
    check("t3_final_const", got, fe_t'(7));

    taus = '{fe_t'(1), fe_t'(1), fe_t'(1)};
    run_gate("t4", 3'b000, fe_t'(1), taus, 1'b0, got);
    check("t4_final_const", got, fe_t'(0));

    taus = '{fe_t'(2), fe_t'(3), fe_t'(5)};
    run_gate("t5", 3'b101, fe_t'(1), taus, 1'b1, got);
    check("t5_final_const", got, F_Q - fe_t'(20));

    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned k = 0; k < N; k++) taus[k] = rand_fe();
      run_gate($sformatf("rnd%0d", r), N'($urandom), rand_fe(), taus, r[0], got);
    end

    // Abort mid-multiply in round 1, then rerun the same gate.
    gate_label = 3'b101; init_val = fe_t'(1); start = 1'b1;
    step();
    start = 1'b0;
    wait_rv("t6_r0");
    tau_valid = 1'b1; tau = fe_t'(2);
    step();
    tau_valid = 1'b0;
    wait_rv("t6_r1");
    tau_valid = 1'b1; tau = fe_t'(3);
    step();
    tau_valid = 1'b0;
    check("t6_in_mul", mul_en, 1);
    #2 rstb = 1'b0;
    #1;
    check("t6_async_reset_outputs",
          {am_en, am_gate_id_bit, am_addmul_in, round_valid, round_idx, mul_en,
           mul_a, mul_b, busy, done_pulse, final_val}, '0);
    step(); step();
    rstb = 1'b1;
    for (int unsigned i = 0; i < 5; i++) step();
    check("t6_no_done_after_abort", done_pulse, 0);
    taus = '{fe_t'(2), fe_t'(3), fe_t'(5)};
    run_gate("t6_rerun", 3'b101, fe_t'(1), taus, 1'b0, got);
    check("t6_final_const", got, F_Q - fe_t'(20));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
